// File: rtl/weight_stream_bank_if.sv
// Handshake and bus bundle for weight_stream_bank: write port, stream request
// and the ready/valid weight stream back to the consumer.
interface weight_stream_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int BANK_W = 1
);
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_start;
    logic [BANK_W-1:0] rd_bank;
    logic [DATA_W-1:0] out_weight;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              busy;

    modport master (
        output wr_en, wr_bank, wr_addr, wr_data, rd_start, rd_bank, out_ready,
        input  out_weight, out_addr, out_valid, out_last, busy
    );

    modport slave (
        input  wr_en, wr_bank, wr_addr, wr_data, rd_start, rd_bank, out_ready,
        output out_weight, out_addr, out_valid, out_last, busy
    );
endinterface

// File: rtl/weight_stream_bank.sv
// Multi-bank weight store. After reset an init sweep fills every entry with
// INIT_VAL; afterwards a bank can be streamed entry 0..DEPTH-1 over a
// ready/valid port while writes continue (read-before-write on collisions).
module weight_stream_bank #(
    parameter int              DATA_W   = 8,
    parameter int              ADDR_W   = 4,
    parameter int              N_BANKS  = 2,
    parameter int              BANK_W   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic                 clk,
    input logic                 rst,
    weight_stream_bank_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    // Bank index width actually needed to address the storage array.
    localparam int BI_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_STREAM} state_t;

    logic [DATA_W-1:0] mem [N_BANKS][DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [BI_W-1:0]   bank_q, bank_d;
    logic [DATA_W-1:0] out_weight_q, out_weight_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic              wr_ok, rd_ok;
    logic [BI_W-1:0]   wr_idx, rd_idx;
    logic [ADDR_W-1:0] addr_nxt;

    // Requests naming a bank beyond N_BANKS are dropped, so only in-range
    // indices ever reach the storage array.
    assign wr_ok    = 32'(bus.wr_bank) < 32'(N_BANKS);
    assign rd_ok    = 32'(bus.rd_bank) < 32'(N_BANKS);
    assign wr_idx   = bus.wr_bank[BI_W-1:0];
    assign rd_idx   = bus.rd_bank[BI_W-1:0];
    assign addr_nxt = out_addr_q + ADDR_W'(1);

    // Next-state and next-beat selection; mem is read before this edge's write.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bank_d       = bank_q;
        out_weight_d = out_weight_q;
        out_addr_d   = out_addr_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.rd_start && rd_ok) begin
                    bank_d       = rd_idx;
                    out_weight_d = mem[rd_idx][0];
                    out_addr_d   = '0;
                    out_valid_d  = 1'b1;
                    out_last_d   = (LAST_ADDR == '0);
                    state_d      = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        out_addr_d   = addr_nxt;
                        out_weight_d = mem[bank_q][addr_nxt];
                        out_last_d   = (addr_nxt == LAST_ADDR);
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Control and output registers; reset abandons any stream and restarts init.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            bank_q       <= '0;
            out_weight_q <= '0;
            out_addr_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bank_q       <= bank_d;
            out_weight_q <= out_weight_d;
            out_addr_q   <= out_addr_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    // Storage: init sweep owns the write port during INIT; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                for (int b = 0; b < N_BANKS; b++) mem[b][cnt_q] <= INIT_VAL;
            end else if (bus.wr_en && wr_ok) begin
                mem[wr_idx][bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.out_weight = out_weight_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_weight_stream_bank.sv
// Bench for weight_stream_bank: directed table-driven scenarios plus a
// randomized run checked cycle by cycle against a behavioural model.
module tb_weight_stream_bank;
    localparam int DATA_W = 8, ADDR_W = 4, N_BANKS = 2, BANK_W = 2;
    localparam int INIT_VAL = 3;
    localparam int DEPTH = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_stream_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

    weight_stream_bank #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_BANKS(N_BANKS), .BANK_W(BANK_W),
        .INIT_VAL(8'(INIT_VAL))
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: memory contents, init cycles remaining, stream cursor.
    int m_mem [N_BANKS][DEPTH];
    int m_init_left = 0;
    bit m_stream = 0;
    int m_bank = 0;
    bit e_valid = 0;
    int e_addr = 0, e_w = 0;

    task automatic model_step();
        if (rst) begin
            m_init_left = DEPTH; m_stream = 0; e_valid = 0; e_addr = 0; e_w = 0;
        end else if (m_init_left > 0) begin
            for (int b = 0; b < N_BANKS; b++) m_mem[b][DEPTH - m_init_left] = INIT_VAL;
            m_init_left--;
        end else begin
            if (!m_stream) begin
                if (bus.rd_start && int'(bus.rd_bank) < N_BANKS) begin
                    m_stream = 1; m_bank = int'(bus.rd_bank);
                    e_addr = 0; e_w = m_mem[m_bank][0]; e_valid = 1;
                end
            end else if (bus.out_ready) begin
                if (e_addr == DEPTH - 1) begin
                    m_stream = 0; e_valid = 0;
                end else begin
                    e_addr++; e_w = m_mem[m_bank][e_addr];
                end
            end
            if (bus.wr_en && int'(bus.wr_bank) < N_BANKS)
                m_mem[int'(bus.wr_bank)][int'(bus.wr_addr)] = int'(bus.wr_data);
        end
    endtask

    // One clock: advance model, let the edge happen, compare on the falling edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("busy", bus.busy, 32'(m_init_left > 0 || m_stream));
        chk("valid", bus.out_valid, 32'(e_valid));
        chk("last", bus.out_last, 32'(e_valid && e_addr == DEPTH - 1));
        if (e_valid) begin
            chk("addr", bus.out_addr, e_addr);
            chk("weight", bus.out_weight, e_w);
        end
    endtask

    int bw[$], ba[$], bl[$];
    int ncyc;
    int exp_w[DEPTH];

    // Request a stream and collect accepted beats; optional poke at iteration poke_at
    // (1: rd_start to the other bank, 2: write bank0 entry 5 = 99).
    task automatic run_stream(input int bank, input bit rnd, input int poke_kind, input int poke_at);
        bit stalled;
        int hw, ha, hl;
        bw.delete(); ba.delete(); bl.delete(); ncyc = 0;
        bus.rd_start = 1'b1; bus.rd_bank = 2'(bank);
        cyc();
        bus.rd_start = 1'b0;
        chk("latency_valid", bus.out_valid, 1);
        for (int it = 0; it < 400 && bus.busy; it++) begin
            bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (it == poke_at && poke_kind == 1) begin
                bus.rd_start = 1'b1; bus.rd_bank = 2'(bank ^ 1);
            end
            if (it == poke_at && poke_kind == 2) begin
                bus.wr_en = 1'b1; bus.wr_bank = 2'd0; bus.wr_addr = 4'd5; bus.wr_data = 8'd99;
            end
            stalled = bus.out_valid && !bus.out_ready;
            hw = int'(bus.out_weight); ha = int'(bus.out_addr); hl = int'(bus.out_last);
            if (bus.out_valid && bus.out_ready) begin
                bw.push_back(int'(bus.out_weight));
                ba.push_back(int'(bus.out_addr));
                bl.push_back(int'(bus.out_last));
            end
            cyc();
            ncyc++;
            bus.rd_start = 1'b0; bus.wr_en = 1'b0;
            if (stalled) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_weight", bus.out_weight, hw);
                chk("hold_addr", bus.out_addr, ha);
                chk("hold_last", bus.out_last, hl);
            end
        end
        chk("stream_done", bus.busy, 0);
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_count"}, bw.size(), DEPTH);
        for (int i = 0; i < bw.size() && i < DEPTH; i++) begin
            chk({tag, "_w"}, bw[i], exp_w[i]);
            chk({tag, "_a"}, ba[i], i);
            chk({tag, "_l"}, bl[i], 32'(i == DEPTH - 1));
        end
    endtask

    typedef struct {
        int wdata;
        int exp_w;
    } wvec_t;

    typedef struct {
        bit rd_start; int rd_bank;
        bit wr_en; int wr_bank; int wr_addr; int wr_data;
        bit exp_busy; bit exp_valid;
    } ivec_t;

    wvec_t wtab[DEPTH];
    ivec_t itab[4];

    initial begin
        int seq[DEPTH] = '{3, 4, 5, 3, 3, 4, 4, 3, 3, 4, 5, 3, 3, 4, 7, 10};
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            wtab[i].wdata = seq[i];
            wtab[i].exp_w = seq[i];
        end
        itab[0] = '{1, 2, 0, 0, 0, 0,  0, 0};
        itab[1] = '{1, 3, 0, 0, 0, 0,  0, 0};
        itab[2] = '{0, 0, 1, 2, 0, 77, 0, 0};
        itab[3] = '{1, 2, 1, 3, 1, 88, 0, 0};

        rst = 1'b1;
        bus.wr_en = 0; bus.wr_bank = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rd_start = 0; bus.rd_bank = 0; bus.out_ready = 0;

        // Reset state and init sweep length
        cyc();
        chk("rst_weight", bus.out_weight, 0);
        chk("rst_addr", bus.out_addr, 0);
        rst = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin cyc(); n++; end
        chk("init_len", n, DEPTH);

        // Bank 1 holds only INIT_VAL
        for (int i = 0; i < DEPTH; i++) exp_w[i] = INIT_VAL;
        run_stream(1, 0, 0, -1);
        check_beats("init_stream");

        // Write bank 0 and stream it back without backpressure
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en = 1; bus.wr_bank = 0; bus.wr_addr = 4'(i); bus.wr_data = 8'(wtab[i].wdata);
            cyc();
        end
        bus.wr_en = 0;
        for (int i = 0; i < DEPTH; i++) exp_w[i] = wtab[i].exp_w;
        run_stream(0, 0, 0, -1);
        check_beats("wr_stream");
        chk("wr_stream_cycles", ncyc, DEPTH);

        // Out-of-range banks are ignored
        for (int i = 0; i < 4; i++) begin
            bus.rd_start = itab[i].rd_start; bus.rd_bank = 2'(itab[i].rd_bank);
            bus.wr_en = itab[i].wr_en; bus.wr_bank = 2'(itab[i].wr_bank);
            bus.wr_addr = 4'(itab[i].wr_addr); bus.wr_data = 8'(itab[i].wr_data);
            cyc();
            chk("ign_busy", bus.busy, 32'(itab[i].exp_busy));
            chk("ign_valid", bus.out_valid, 32'(itab[i].exp_valid));
        end
        bus.rd_start = 0; bus.wr_en = 0;

        // Backpressure: same sequence, bank0 untouched by ignored writes
        run_stream(0, 1, 0, -1);
        check_beats("bp_stream");

        // rd_start mid-stream is ignored
        for (int i = 0; i < DEPTH; i++) exp_w[i] = INIT_VAL;
        run_stream(1, 0, 1, 3);
        check_beats("midstart");

        // Collision: entry 5 written while it is being loaded
        for (int i = 0; i < DEPTH; i++) exp_w[i] = wtab[i].exp_w;
        run_stream(0, 0, 2, 4);
        check_beats("coll_old");
        exp_w[5] = 99;
        run_stream(0, 0, 0, -1);
        check_beats("coll_new");

        // Reset in the middle of a stream
        bus.out_ready = 1; bus.rd_start = 1; bus.rd_bank = 0;
        cyc();
        bus.rd_start = 0;
        repeat (7) cyc();
        chk("mid_addr", bus.out_addr, 7);
        rst = 1'b1;
        cyc();
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_busy", bus.busy, 1);
        chk("mrst_addr", bus.out_addr, 0);
        chk("mrst_weight", bus.out_weight, 0);
        chk("mrst_last", bus.out_last, 0);
        rst = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin cyc(); n++; end
        chk("mrst_init_len", n, DEPTH);

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            bus.wr_en = $urandom_range(0, 1) != 0;
            bus.wr_bank = 2'($urandom_range(0, 3));
            bus.wr_addr = 4'($urandom_range(0, DEPTH - 1));
            bus.wr_data = 8'($urandom_range(0, 255));
            bus.rd_start = ($urandom_range(0, 4) == 0);
            bus.rd_bank = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_stream_bank.md
WEIGHT_STREAM_BANK -- requirements
Module: weight_stream_bank

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 8, weight width in bits.
- ADDR_W, 4, entry address width; DEPTH = 2^ADDR_W entries per bank.
- N_BANKS, 2, number of independent weight banks (channels); minimum 1.
- BANK_W, 1, bank-select width; BANK_W >= max(1, clog2(N_BANKS)).
- INIT_VAL, 0, value written into every entry by the post-reset init sweep.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- wr_en, in, 1, write strobe.
- wr_bank, in, BANK_W, bank to write.
- wr_addr, in, ADDR_W, entry to write.
- wr_data, in, DATA_W, weight value to write.
- rd_start, in, 1, single-cycle request to stream one bank.
- rd_bank, in, BANK_W, bank to stream; sampled with rd_start.
- out_weight, out, DATA_W, streamed weight.
- out_addr, out, ADDR_W, entry index of out_weight.
- out_valid, out, 1, out_weight/out_addr valid.
- out_last, out, 1, current beat is entry DEPTH-1.
- out_ready, in, 1, downstream accepts beat.
- busy, out, 1, init sweep or stream in progress.
REQ-003 The single clock SHALL be clk, and reset SHALL be rst, synchronous and active-high.

Function
REQ-004 Storage SHALL be N_BANKS x DEPTH entries of DATA_W bits.
REQ-005 The FSM SHALL have three states, INIT, IDLE and STREAM; rst forces INIT and clears the address counter.
REQ-006 INIT SHALL write INIT_VAL to entry k of every bank on the k-th cycle after rst deasserts (k = 0..DEPTH-1), then go to IDLE; it takes exactly DEPTH cycles.
REQ-007 In INIT, busy SHALL be 1, and wr_en and rd_start SHALL be ignored.
REQ-008 In IDLE, busy SHALL be 0 and out_valid SHALL be 0.
REQ-009 In IDLE, wr_en=1 with wr_bank < N_BANKS SHALL write wr_data at the next edge; wr_bank >= N_BANKS SHALL be ignored.
REQ-010 In IDLE, rd_start=1 with rd_bank < N_BANKS SHALL latch rd_bank, load out_weight with mem[rd_bank][0] and out_addr with 0, set out_valid at the next edge, and enter STREAM; latency is 1 cycle.
REQ-011 rd_start with rd_bank >= N_BANKS SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-012 In STREAM, busy SHALL be 1.
REQ-013 In STREAM, out_weight, out_addr and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 A handshake is out_valid=1 and out_ready=1; on a handshake with out_addr < DEPTH-1, the block SHALL load mem[bank][out_addr+1] and out_addr+1 at the next edge, with no bubble.
REQ-015 out_last SHALL equal (out_addr == DEPTH-1) while out_valid=1, and 0 otherwise.
REQ-016 A handshake on out_last SHALL clear out_valid and return to IDLE at the next edge, so a new rd_start is accepted on the following cycle.
REQ-017 rd_start during STREAM SHALL be ignored.
REQ-018 Writes SHALL be accepted in STREAM, to any bank.
REQ-019 Collisions SHALL resolve as read-before-write:
- A write to the entry being loaded into out_weight in the same cycle SHALL NOT affect the loaded value.
- A write to an already-loaded entry SHALL NOT change the held out_weight.
REQ-020 Write and rd_start in the same IDLE cycle SHALL both take effect, with read-before-write on entry 0.
REQ-021 Address arithmetic SHALL be unsigned ADDR_W bits, and out_addr SHALL never wrap within a stream.

Reset
REQ-022 On rst=1 at any time, including mid-INIT or mid-STREAM, the block SHALL at the next edge set out_valid=0, out_last=0, out_weight=0, out_addr=0, busy=1 and state=INIT, abandoning any stream.
REQ-023 Memory contents SHALL NOT be cleared by rst itself; the following INIT sweep SHALL overwrite every entry with INIT_VAL.

Verification
REQ-024 The bench SHALL cover these directed scenarios (default parameters unless noted):
- Init: rst 1 cycle, then INIT_VAL=3 -> busy=1 for exactly 16 cycles; streaming bank 1 then gives 16 beats of 3 with out_addr 0..15, out_last only on beat 15.
- Write/stream: write bank0 entries 0..15 = {3,4,5,3,3,4,4,3,3,4,5,3,3,4,7,10}, rd_start bank0, out_ready=1 -> first beat 1 cycle later, 16 consecutive beats in that order, then busy=0.
- Backpressure: out_ready toggled pseudo-randomly -> outputs stable while stalled, no beat lost or duplicated, and the sequence matches the previous scenario.
- Collision: during the stream, write entry 5 = 99 on the cycle entry 5 is loaded -> stream shows the old 4; the next stream shows 99.
- Illegal/ignored inputs: rd_start with rd_bank=2 (N_BANKS=2) -> stays IDLE; rd_start mid-stream -> no effect.
- Reset mid-stream: rst asserted at beat 7 -> out_valid=0 at the next edge, then a full 16-cycle INIT sweep.
